// File: rtl/passcode_ctrl.sv
// Passcode entry controller: collects 2-bit digits from one-hot button pulses,
// unlocks on a match and locks out after repeated failures. Optional macro:
// PASSCODE_TIMEOUT_EN adds a 64-cycle inactivity timeout during digit entry.
module passcode_ctrl #(
  parameter int unsigned               CODE_LEN      = 4,
  parameter logic [2*CODE_LEN-1:0]     CODE          = 8'b00_11_01_10,
  parameter int unsigned               MAX_TRIES     = 3,
  parameter int unsigned               UNLOCK_CYCLES = 8,
  parameter int unsigned               LOCK_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] btn,
  output logic       unlocked,
  output logic       alarm,
  output logic       busy,
  output logic [3:0] digit_cnt,
  output logic [3:0] fail_cnt
);

  localparam int unsigned DUR_MAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned DUR_W   = (DUR_MAX < 2) ? 1 : $clog2(DUR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_UNLOCK, S_FAIL, S_LOCKOUT
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              dcnt_q, dcnt_d;
  logic [3:0]              fail_q, fail_d;
  logic                    mis_q, mis_d;
  logic [1:0]              slot_q [CODE_LEN];
  logic [1:0]              slot_d [CODE_LEN];
  logic [DUR_W-1:0]        dur_q, dur_d;
`ifdef PASSCODE_TIMEOUT_EN
  logic [5:0]              to_q, to_d;
`endif

  logic                    valid;
  logic [1:0]              digit;
  logic [1:0]              code_dig;
  logic [2*CODE_LEN-1:0]   entered;
  logic [3:0]              fail_inc;

  assign valid    = $onehot(btn);
  assign fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

  always_comb begin
    case (btn)
      4'b0010: digit = 2'd1;
      4'b0100: digit = 2'd2;
      4'b1000: digit = 2'd3;
      default: digit = 2'd0;
    endcase
  end

  // Expected digit for the slot being written, and the whole entry packed like CODE.
  always_comb begin
    code_dig = '0;
    entered  = '0;
    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (4'(i) == dcnt_q) code_dig = CODE[2*i +: 2];
      entered[2*i +: 2] = slot_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    fail_d  = fail_q;
    mis_d   = mis_q;
    slot_d  = slot_q;
    dur_d   = dur_q;
`ifdef PASSCODE_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          slot_d[0] = digit;
          dcnt_d    = 4'd1;
          mis_d     = (digit != CODE[1:0]);
          state_d   = (CODE_LEN == 1) ? S_CHECK : S_ENTRY;
`ifdef PASSCODE_TIMEOUT_EN
          to_d      = '1;
`endif
        end
      end
      S_ENTRY: begin
        if (valid) begin
          for (int unsigned i = 0; i < CODE_LEN; i++)
            if (4'(i) == dcnt_q) slot_d[i] = digit;
          dcnt_d = dcnt_q + 4'd1;
          mis_d  = mis_q | (digit != code_dig);
          if ((dcnt_q + 4'd1) == 4'(CODE_LEN)) state_d = S_CHECK;
`ifdef PASSCODE_TIMEOUT_EN
          to_d   = '1;
        end else if (to_q == '0) begin
          state_d = S_IDLE;
          dcnt_d  = '0;
          mis_d   = 1'b0;
        end else begin
          to_d = to_q - 6'd1;
`endif
        end
      end
      S_CHECK: begin
        if (!mis_q && (entered == CODE)) begin
          state_d = S_UNLOCK;
          fail_d  = '0;
          dcnt_d  = '0;
          dur_d   = DUR_W'(UNLOCK_CYCLES - 1);
        end else begin
          state_d = S_FAIL;
        end
      end
      S_UNLOCK: begin
        if (dur_q == '0) state_d = S_IDLE;
        else             dur_d   = dur_q - 1'b1;
      end
      S_FAIL: begin
        fail_d = fail_inc;
        dcnt_d = '0;
        mis_d  = 1'b0;
        if (32'(fail_inc) >= MAX_TRIES) begin
          state_d = S_LOCKOUT;
          dur_d   = DUR_W'(LOCK_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (dur_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          dur_d = dur_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      fail_q  <= '0;
      mis_q   <= 1'b0;
      dur_q   <= '0;
      for (int unsigned i = 0; i < CODE_LEN; i++) slot_q[i] <= '0;
`ifdef PASSCODE_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      fail_q  <= fail_d;
      mis_q   <= mis_d;
      dur_q   <= dur_d;
      slot_q  <= slot_d;
`ifdef PASSCODE_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign unlocked  = (state_q == S_UNLOCK);
  assign alarm     = (state_q == S_LOCKOUT);
  assign busy      = (state_q == S_CHECK) || (state_q == S_UNLOCK) ||
                     (state_q == S_FAIL)  || (state_q == S_LOCKOUT);
  assign digit_cnt = dcnt_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_passcode_ctrl.sv
// Self-checking bench for passcode_ctrl: vector table, directed corner cases
// and randomized presses against a queue-based reference model.
module tb_passcode_ctrl;

  localparam int unsigned CODE_LEN      = 4;
  localparam logic [7:0]  CODE          = 8'b00_11_01_10;
  localparam int unsigned MAX_TRIES     = 3;
  localparam int unsigned UNLOCK_CYCLES = 8;
  localparam int unsigned LOCK_CYCLES   = 16;
  localparam logic [7:0]  WRONG         = 8'b01_11_01_10;  // 2,1,3,1

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] btn;
  logic       unlocked, alarm, busy;
  logic [3:0] digit_cnt, fail_cnt;

  int n_total = 0;
  int n_pass  = 0;

  passcode_ctrl #(
    .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_TRIES(MAX_TRIES),
    .UNLOCK_CYCLES(UNLOCK_CYCLES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .clr(clr), .btn(btn), .unlocked(unlocked), .alarm(alarm),
    .busy(busy), .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: entered digits in a queue plus remaining-cycle counts.
  int mq[$];
  int m_fails, m_ulk, m_lck;
  bit m_chk, m_fl;

  function automatic int code_digit(int i);
    return (int'(CODE) >> (2 * i)) & 3;
  endfunction

  function automatic bit is_onehot(logic [3:0] b);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(b[i]);
    return n == 1;
  endfunction

  function automatic int btn_digit(logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return 0;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_fails = 0; m_ulk = 0; m_lck = 0; m_chk = 0; m_fl = 0;
  endtask

  task automatic m_step(input logic [3:0] b);
    if (m_chk) begin
      bit ok;
      ok = 1;
      m_chk = 0;
      for (int i = 0; i < int'(CODE_LEN); i++) if (mq[i] != code_digit(i)) ok = 0;
      if (ok) begin
        m_ulk = UNLOCK_CYCLES; m_fails = 0; mq.delete();
      end else m_fl = 1;
    end else if (m_fl) begin
      m_fl = 0;
      m_fails = (m_fails >= 15) ? 15 : m_fails + 1;
      mq.delete();
      if (m_fails >= int'(MAX_TRIES)) m_lck = LOCK_CYCLES;
    end else if (m_ulk > 0) begin
      m_ulk--;
    end else if (m_lck > 0) begin
      m_lck--;
      if (m_lck == 0) m_fails = 0;
    end else if (is_onehot(b)) begin
      mq.push_back(btn_digit(b));
      if (mq.size() == int'(CODE_LEN)) m_chk = 1;
    end
  endtask

  function automatic logic [10:0] model_out();
    logic bsy;
    bsy = m_chk || m_fl || (m_ulk > 0) || (m_lck > 0);
    return {m_ulk > 0, m_lck > 0, bsy, 4'(mq.size()), 4'(m_fails)};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic step(input logic [3:0] b);
    btn = b;
    @(posedge clk);
    m_step(b);
    #1;
  endtask

  task automatic do_reset();
    #2 clr = 1'b0;
    btn = '0;
    #1 check("reset_outputs", {21'd0, unlocked, alarm, busy, digit_cnt, fail_cnt}, 32'd0);
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #3 clr = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in CHECK after the final digit.
  task automatic press_code(input logic [7:0] seq);
    for (int i = 0; i < 4; i++) begin
      step(4'(1) << seq[2*i +: 2]);
      if (i < 3) step('0);
    end
  endtask

  typedef struct {
    logic [3:0] b;
    logic       unl;
    logic       alm;
    logic       bsy;
    logic [3:0] dc;
    logic [3:0] fc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int cnt;
    tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[1]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    tbl[2]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
    tbl[4]  = '{4'b0110, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0};
    tbl[5]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0};
    tbl[7]  = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0};
    tbl[8]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'd4, 4'd0};
    tbl[9]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0};
    tbl[10] = '{4'b0001, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0};

    clr = 1'b0;
    btn = '0;
    m_reset();
    #2 check("por_outputs", {21'd0, unlocked, alarm, busy, digit_cnt, fail_cnt}, 32'd0);
    @(posedge clk);
    #3 clr = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: each row's outputs are observed after its button cycle.
    foreach (tbl[i]) begin
      step(tbl[i].b);
      check($sformatf("table_%0d", i), {21'd0, unlocked, alarm, busy, digit_cnt, fail_cnt},
            {21'd0, tbl[i].unl, tbl[i].alm, tbl[i].bsy, tbl[i].dc, tbl[i].fc});
    end
    repeat (8) step('0);
    check("table_unlock_end", {30'd0, unlocked, busy}, 32'd0);

    // Timed entry: presses on cycles 10,14,18,22; state after each step is cycle c+1.
    do_reset();
    for (int c = 0; c < 34; c++) begin
      logic [3:0] b;
      int nc;
      case (c)
        10: b = 4'b0100;
        14: b = 4'b0010;
        18: b = 4'b1000;
        22: b = 4'b0001;
        default: b = 4'b0000;
      endcase
      step(b);
      nc = c + 1;
      check($sformatf("timed_unl_c%0d", nc), {31'd0, unlocked}, {31'd0, (nc >= 24 && nc <= 31)});
      check($sformatf("timed_busy_c%0d", nc), {31'd0, busy}, {31'd0, (nc >= 23 && nc <= 31)});
    end
    check("timed_idle_counts", {24'd0, digit_cnt, fail_cnt}, 32'd0);

    // Three wrong entries lead to lockout; presses during lockout are ignored.
    for (int k = 1; k <= 3; k++) begin
      press_code(WRONG);
      step('0);
      step('0);
      check($sformatf("fail_cnt_%0d", k), {28'd0, fail_cnt}, 32'(k));
      check($sformatf("alarm_after_fail_%0d", k), {31'd0, alarm}, {31'd0, k == 3});
    end
    cnt = alarm ? 1 : 0;
    for (int j = 0; j < 40 && alarm; j++) begin
      step(4'b0100);
      check("lockout_dc_zero", {28'd0, digit_cnt}, 32'd0);
      if (alarm) cnt++;
    end
    check("lockout_len", 32'(cnt), 32'(LOCK_CYCLES));
    check("lockout_exit", {23'd0, alarm, digit_cnt, fail_cnt}, 32'd0);
    step('0);

    // One wrong entry followed by a correct one.
    press_code(WRONG);
    step('0);
    step('0);
    check("single_fail", {28'd0, fail_cnt}, 32'd1);
    press_code(CODE);
    step('0);
    check("recover_unlock", {27'd0, unlocked, fail_cnt}, {27'd0, 1'b1, 4'd0});
    repeat (8) step('0);

    // Reset mid-entry, then a full correct entry.
    step(4'b0100); step('0); step(4'b0010); step('0);
    check("mid_entry_dc", {28'd0, digit_cnt}, 32'd2);
    do_reset();
    press_code(CODE);
    step('0);
    check("after_entry_reset", {31'd0, unlocked}, 32'd1);
    step('0); step('0);
    check("unlock_cycle3", {31'd0, unlocked}, 32'd1);
    do_reset();
    press_code(CODE);
    step('0);
    check("after_unlock_reset", {31'd0, unlocked}, 32'd1);
    repeat (8) step('0);

    // Randomized presses against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [3:0] b;
      r = int'($urandom_range(0, 9));
      if (r < 4)       b = '0;
      else if (r < 7)  b = 4'(1) << code_digit(mq.size() % int'(CODE_LEN));
      else if (r == 7) b = 4'(1) << $urandom_range(0, 3);
      else             b = 4'($urandom);
      step(b);
      check("random_vs_model", {21'd0, unlocked, alarm, busy, digit_cnt, fail_cnt},
            {21'd0, model_out()});
    end

`ifdef PASSCODE_TIMEOUT_EN
    do_reset();
    step(4'b0100); step(4'b0010);
    repeat (63) step('0);
    check("timeout_before", {28'd0, digit_cnt}, 32'd2);
    step('0);
    check("timeout_expired", {27'd0, busy, digit_cnt}, 32'd0);
    press_code(CODE);
    step('0);
    check("timeout_then_unlock", {31'd0, unlocked}, 32'd1);
`endif

    btn = '0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
